// File: rtl/mem_pkg.sv
// Shared types for the data-memory access controller: access size and FSM state.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } mac_state_t;

    // funct3[1:0] == 2'b11 has no defined size; it is handled as a word.
    function automatic mem_size_t decode_size(input logic [1:0] f);
        case (f)
            2'b00:   decode_size = MEM_B;
            2'b01:   decode_size = MEM_H;
            default: decode_size = MEM_W;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/half lane out of a read word and sign- or zero-extends it.
module load_extender
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ext_data
);

    logic signed [7:0]  byte_lane;
    logic signed [15:0] half_lane;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

        ext_data = rdata;
        if (size == MEM_B) begin
            if (is_unsigned) ext_data = {24'd0, byte_lane};
            else             ext_data = {{24{byte_lane[7]}}, byte_lane};
        end else if (size == MEM_H) begin
            if (is_unsigned) ext_data = {16'd0, half_lane};
            else             ext_data = {{16{half_lane[15]}}, half_lane};
        end
    end

endmodule

// File: rtl/mem_access_controller.sv
// Load/store sequencer on a req/gnt/rvalid data-memory port with pipeline stall and timeout.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of truncating the address.
module mem_access_controller
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_MEMPREP,
    input  logic        invalid_MEMPREP,
    input  logic        is_store_MEMPREP,
    input  logic [2:0]  funct3_MEMPREP,
    input  logic [31:0] addr_MEMPREP,
    input  logic [31:0] wdata_MEMPREP,
    input  logic [3:0]  rd_MEMPREP,
    output logic        stall_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        load_valid_MEMEX,
    output logic [31:0] load_data_MEMEX,
    output logic [3:0]  rd_MEMEX,
    output logic        bus_error_MEMEX
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misaligned_MEMEX
`endif
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    mac_state_t  state, state_next;
    mem_size_t   size_in, req_size;
    logic [1:0]  off_in, req_off;
    logic [29:0] req_word;
    logic        req_we, req_unsigned;
    logic [31:0] req_wdata, ext_data, tmo_cnt;
    logic [3:0]  req_rd;
    logic        accept, done_load, done_store, timeout;

    // Offset is forced to size alignment so lane/strobe selection never straddles.
    always_comb begin
        size_in = decode_size(funct3_MEMPREP[1:0]);
        case (size_in)
            MEM_B:   off_in = addr_MEMPREP[1:0];
            MEM_H:   off_in = {addr_MEMPREP[1], 1'b0};
            default: off_in = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned_in;
    assign misaligned_in = ((size_in == MEM_H) && addr_MEMPREP[0]) ||
                           ((size_in == MEM_W) && (addr_MEMPREP[1:0] != 2'b00));
    assign accept = (state == IDLE) && mem_valid_MEMPREP && !invalid_MEMPREP && !misaligned_in;
`else
    assign accept = (state == IDLE) && mem_valid_MEMPREP && !invalid_MEMPREP;
`endif

    // rvalid counts in REQ only alongside gnt; in IDLE it is never looked at.
    assign done_load  = !req_we && (((state == REQ) && dmem_gnt && dmem_rvalid) ||
                                    ((state == WAIT) && dmem_rvalid));
    assign done_store = req_we && (state == REQ) && dmem_gnt;
    assign timeout    = (state != IDLE) && (TIMEOUT_CYCLES != 0) &&
                        (tmo_cnt == TMO_LAST) && !(done_load || done_store);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = REQ;
            REQ: begin
                if (done_load || done_store || timeout) state_next = IDLE;
                else if (dmem_gnt)                      state_next = WAIT;
            end
            WAIT: if (done_load || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall_MEM  = accept || (state != IDLE);
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        dmem_wstrb = 4'd0;
        if (state == REQ) begin
            dmem_req  = 1'b1;
            dmem_we   = req_we;
            dmem_addr = {req_word, 2'b00};
            case (req_size)
                MEM_B: begin
                    dmem_wdata = {4{req_wdata[7:0]}};
                    dmem_wstrb = 4'b0001 << req_off;
                end
                MEM_H: begin
                    dmem_wdata = {2{req_wdata[15:0]}};
                    dmem_wstrb = 4'b0011 << req_off;
                end
                default: begin
                    dmem_wdata = req_wdata;
                    dmem_wstrb = 4'b1111;
                end
            endcase
        end
    end

    // Request capture: data path only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_word     <= addr_MEMPREP[31:2];
            req_off      <= off_in;
            req_size     <= size_in;
            req_unsigned <= funct3_MEMPREP[2];
            req_we       <= is_store_MEMPREP;
            req_wdata    <= wdata_MEMPREP;
            req_rd       <= rd_MEMPREP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE) || (state_next == IDLE)) tmo_cnt <= 32'd0;
        else                                                tmo_cnt <= tmo_cnt + 32'd1;
    end

    load_extender u_ext (
        .rdata       (dmem_rdata),
        .offset      (req_off),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .ext_data    (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            load_valid_MEMEX <= 1'b0;
            bus_error_MEMEX  <= 1'b0;
            load_data_MEMEX  <= 32'd0;
            rd_MEMEX         <= 4'd0;
        end else begin
            load_valid_MEMEX <= done_load;
            bus_error_MEMEX  <= timeout;
            if (done_load) begin
                load_data_MEMEX <= ext_data;
                rd_MEMEX        <= req_rd;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) misaligned_MEMEX <= 1'b0;
        else     misaligned_MEMEX <= (state == IDLE) && mem_valid_MEMPREP &&
                                     !invalid_MEMPREP && misaligned_in;
    end
`endif

endmodule
